mem_stage_ws: RTL and testbench

- Parametrised successor to the single-cycle MIPS MEM stage. Sits between EX and WB and owns the data RAM.
- Adds sub-word loads and stores (byte/halfword, signed and unsigned), per-byte write enables, and configurable RAM wait states.
- Upstream stall handshake via in_ready; misaligned-access exception flag.
- One access in flight at a time. Every output is registered.

---
 rtl/mem_stage_ws_if.sv | 26 ++
 rtl/mem_stage_ws.sv | 191 +++++++++++++++++++
 tb/tb_mem_stage_ws.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_ws_if.sv
// EX -> MEM -> WB handshake bundle for mem_stage_ws.
// master = upstream/downstream environment, slave = the MEM stage itself.
interface mem_stage_ws_if;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  opcode;
  logic [31:0] eff_addr;
  logic [31:0] rt_value;
  logic [4:0]  rt_addr;
  logic        reg_write_in;
  logic        out_valid;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        misalign_exc;

  modport master (
    output in_valid, opcode, eff_addr, rt_value, rt_addr, reg_write_in,
    input  in_ready, out_valid, wb_en, wb_addr, wb_data, misalign_exc
  );

  modport slave (
    input  in_valid, opcode, eff_addr, rt_value, rt_addr, reg_write_in,
    output in_ready, out_valid, wb_en, wb_addr, wb_data, misalign_exc
  );
endinterface

// File: rtl/mem_stage_ws.sv
// MIPS MEM stage with sub-word loads/stores, byte-lane write enables and
// configurable RAM wait states. One access in flight; all outputs registered.
module mem_stage_ws #(
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic          clk,
  input  logic          rst,
  mem_stage_ws_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101011;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  op_q;
  logic [31:0] addr_q, data_q;
  logic [4:0]  rt_q;
  logic        rw_q;

  logic        in_ready_q, out_valid_q, wb_en_q, misal_q;
  logic [4:0]  wb_addr_q;
  logic [31:0] wb_data_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [5:0]  op_c;
  logic [31:0] addr_c, data_c;
  logic [4:0]  rt_c;
  logic        rw_c;
  logic        accept, is_load, is_store, mem_op, misal, finish, we;
  logic [AW-1:0] idx;
  logic [3:0]  byte_en;
  logic [31:0] wdata, rd_word, rd_shift, load_val;

  assign accept = bus.in_valid && (state_q == S_IDLE);

  // Zero-wait accesses complete on the accept edge, so the live inputs are
  // used while IDLE and the latched copy afterwards.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    op_c   = op_q;
    addr_c = addr_q;
    data_c = data_q;
    rt_c   = rt_q;
    rw_c   = rw_q;
    if (state_q == S_IDLE) begin
      op_c   = bus.opcode;
      addr_c = bus.eff_addr;
      data_c = bus.rt_value;
      rt_c   = bus.rt_addr;
      rw_c   = bus.reg_write_in;
    end
  end

  always_comb begin
    is_load  = (op_c == OP_LB) || (op_c == OP_LH) || (op_c == OP_LW) ||
               (op_c == OP_LBU) || (op_c == OP_LHU);
    is_store = (op_c == OP_SB) || (op_c == OP_SH) || (op_c == OP_SW);
    mem_op   = is_load || is_store;
    idx      = addr_c[AW+1:2];

    misal = 1'b0;
    case (op_c)
      OP_LW, OP_SW:         misal = |addr_c[1:0];
      OP_LH, OP_LHU, OP_SH: misal = addr_c[0];
      default:              misal = 1'b0;
    endcase

    byte_en = 4'b1111;
    wdata   = data_c;
    case (op_c)
      OP_SB: begin
        byte_en = 4'b0001 << addr_c[1:0];
        wdata   = {4{data_c[7:0]}};
      end
      OP_SH: begin
        byte_en = addr_c[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{data_c[15:0]}};
      end
      default: ;
    endcase

    rd_word  = mem[idx];
    rd_shift = rd_word >> {addr_c[1:0], 3'b000};
    case (op_c)
      OP_LB:   load_val = {{24{rd_shift[7]}}, rd_shift[7:0]};
      OP_LBU:  load_val = {24'h0, rd_shift[7:0]};
      OP_LH:   load_val = {{16{rd_shift[15]}}, rd_shift[15:0]};
      OP_LHU:  load_val = {16'h0, rd_shift[15:0]};
      default: load_val = rd_word;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (!mem_op || misal || (WAIT_STATES == 0)) begin
            state_d = S_DONE;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign finish = (state_d == S_DONE);
  assign we     = finish && is_store && !misal && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      op_q        <= 6'd0;
      addr_q      <= 32'd0;
      data_q      <= 32'd0;
      rt_q        <= 5'd0;
      rw_q        <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      wb_en_q     <= 1'b0;
      misal_q     <= 1'b0;
      wb_addr_q   <= 5'd0;
      wb_data_q   <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= (state_d == S_IDLE);
      out_valid_q <= finish;
      wb_en_q     <= 1'b0;
      misal_q     <= 1'b0;
      if (accept) begin
        op_q   <= bus.opcode;
        addr_q <= bus.eff_addr;
        data_q <= bus.rt_value;
        rt_q   <= bus.rt_addr;
        rw_q   <= bus.reg_write_in;
      end
      if (finish) begin
        misal_q   <= misal;
        wb_addr_q <= rt_c;
        if (!mem_op) begin
          wb_en_q   <= rw_c;
          wb_data_q <= addr_c;
        end else if (is_load && !misal) begin
          wb_en_q   <= 1'b1;
          wb_data_q <= load_val;
        end
      end
    end
  end

  // NOTE: the RAM array has no reset; its contents survive rst by design.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < 4; k++) begin
        if (byte_en[k]) mem[idx][8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

  assign bus.in_ready     = in_ready_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.wb_en        = wb_en_q;
  assign bus.wb_addr      = wb_addr_q;
  assign bus.wb_data      = wb_data_q;
  assign bus.misalign_exc = misal_q;
endmodule

// File: tb/tb_mem_stage_ws.sv
// Self-checking bench: a zero-wait and a three-wait instance driven by directed
// and random ops, checked against a word-array reference model.
module tb_mem_stage_ws;
  localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25;
  localparam logic [5:0] SB = 6'h28, SH = 6'h29, SW = 6'h2B;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [31:0] last_wd;
  logic [31:0] model [2][1024];
  logic [5:0]  mem_ops [8] = '{LB, LH, LW, LBU, LHU, SB, SH, SW};

  always #5 clk = ~clk;

  mem_stage_ws_if if0 ();
  mem_stage_ws_if if3 ();

  mem_stage_ws #(.DATA_W(32), .DEPTH(1024), .WAIT_STATES(0)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
  mem_stage_ws #(.DATA_W(32), .DEPTH(1024), .WAIT_STATES(3)) dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input int d, input logic v, input logic [5:0] opc, input logic [31:0] a,
                        input logic [31:0] dat, input logic [4:0] rt, input logic rw);
    if (d == 0) begin
      if0.in_valid = v; if0.opcode = opc; if0.eff_addr = a;
      if0.rt_value = dat; if0.rt_addr = rt; if0.reg_write_in = rw;
    end else begin
      if3.in_valid = v; if3.opcode = opc; if3.eff_addr = a;
      if3.rt_value = dat; if3.rt_addr = rt; if3.reg_write_in = rw;
    end
  endtask

  task automatic set_valid(input int d, input logic v);
    if (d == 0) if0.in_valid = v;
    else        if3.in_valid = v;
  endtask

  task automatic sample(input int d, output logic ov, output logic ir, output logic we,
                        output logic [4:0] wa, output logic [31:0] wd, output logic me);
    if (d == 0) begin
      ov = if0.out_valid; ir = if0.in_ready; we = if0.wb_en;
      wa = if0.wb_addr; wd = if0.wb_data; me = if0.misalign_exc;
    end else begin
      ov = if3.out_valid; ir = if3.in_ready; we = if3.wb_en;
      wa = if3.wb_addr; wd = if3.wb_data; me = if3.misalign_exc;
    end
  endtask

  // Called at a negedge with the selected instance idle; returns at a negedge with it idle.
  task automatic op(input int d, input logic [5:0] opc, input logic [31:0] a, input logic [31:0] dat,
                    input logic [4:0] rt, input logic rw, input bit hold, input int rst_at);
    bit ld, st, mis, mem_op;
    int lat, k, idx;
    logic [31:0] w, exp_data, mask;
    logic exp_en, ov, ir, we, me;
    logic [4:0] wa;
    logic [31:0] wd;

    ld     = (opc == LB) || (opc == LH) || (opc == LW) || (opc == LBU) || (opc == LHU);
    st     = (opc == SB) || (opc == SH) || (opc == SW);
    mem_op = ld || st;
    mis    = ((opc == LW || opc == SW) && (a % 4 != 0)) ||
             ((opc == LH || opc == LHU || opc == SH) && (a % 2 != 0));
    lat    = (!mem_op || mis) ? 1 : 1 + (d == 0 ? 0 : 3);
    idx    = int'((a / 4) % 1024);
    k      = int'(a % 4);
    w      = model[d][idx];
    exp_en = mis ? 1'b0 : ld ? 1'b1 : st ? 1'b0 : rw;

    exp_data = a;
    case (opc)
      LB:  begin exp_data = (w >> (8 * k)) & 32'hFF;   if (exp_data >= 128)   exp_data += 32'hFFFFFF00; end
      LBU: exp_data = (w >> (8 * k)) & 32'hFF;
      LH:  begin exp_data = (w >> (8 * k)) & 32'hFFFF; if (exp_data >= 32768) exp_data += 32'hFFFF0000; end
      LHU: exp_data = (w >> (8 * k)) & 32'hFFFF;
      LW:  exp_data = w;
      default: ;
    endcase

    sample(d, ov, ir, we, wa, wd, me);
    check("in_ready_before_accept", ir, 1'b1);
    set_in(d, 1'b1, opc, a, dat, rt, rw);
    @(posedge clk);
    for (int n = 1; n <= lat + 1; n++) begin
      @(negedge clk);
      if (!hold || n == lat + 1) set_valid(d, 1'b0);
      sample(d, ov, ir, we, wa, wd, me);
      if (rst_at == 0) begin
        check("out_valid", ov, (n == lat));
        check("in_ready", ir, (n == lat + 1));
        if (n == lat) begin
          check("misalign_exc", me, mis);
          check("wb_en", we, exp_en);
          if (exp_en) check("wb_addr", wa, rt);
          if (!mem_op || (ld && !mis)) begin
            check("wb_data", wd, exp_data);
            last_wd = wd;
          end
        end else begin
          check("wb_en_idle", we, 1'b0);
          check("misalign_idle", me, 1'b0);
        end
      end else begin
        check("rst_out_valid", ov, 1'b0);
        if (n > rst_at) check("rst_in_ready", ir, 1'b1);
        if (n == rst_at) rst = 1'b1;
        else if (n == rst_at + 1) rst = 1'b0;
      end
    end

    if (rst_at == 0 && st && !mis) begin
      case (opc)
        SB: begin mask = 32'hFF << (8 * k);   model[d][idx] = (w & ~mask) | ((dat & 32'hFF) << (8 * k)); end
        SH: begin mask = 32'hFFFF << (8 * k); model[d][idx] = (w & ~mask) | ((dat & 32'hFFFF) << (8 * k)); end
        default: model[d][idx] = dat;
      endcase
    end
  endtask

  initial begin
    logic ov, ir, we, me;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [5:0]  ropc;
    logic [31:0] ra;
    int rd;

    set_in(0, 1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    set_in(1, 1'b0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int d = 0; d < 2; d++) begin
      sample(d, ov, ir, we, wa, wd, me);
      check("reset_in_ready", ir, 1'b1);
      check("reset_out_valid", ov, 1'b0);
      check("reset_wb_en", we, 1'b0);
      check("reset_wb_addr", wa, 5'd0);
      check("reset_wb_data", wd, 32'd0);
      check("reset_misalign", me, 1'b0);
    end

    // Give a known value to the words the rest of the run touches.
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++)
        op(d, SW, 32'(i * 4), $urandom(), 5'd0, 1'b0, 1'b0, 0);

    // Word store and load, zero wait.
    op(0, SW, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0, 1'b0, 0);
    op(0, LW, 32'h10, 32'h0, 5'd5, 1'b0, 1'b0, 0);
    check("t1_lw_data", last_wd, 32'hDEADBEEF);

    // Sub-word stores and loads.
    op(0, SB, 32'h13, 32'h0000007F, 5'd0, 1'b0, 1'b0, 0);
    op(0, LB,  32'h12, 32'h0, 5'd1, 1'b0, 1'b0, 0);
    op(0, LBU, 32'h12, 32'h0, 5'd2, 1'b0, 1'b0, 0);
    op(0, LH,  32'h12, 32'h0, 5'd3, 1'b0, 1'b0, 0);
    check("t2_lh_12", last_wd, 32'h00007FAD);
    op(0, LHU, 32'h12, 32'h0, 5'd4, 1'b0, 1'b0, 0);
    op(0, LB,  32'h13, 32'h0, 5'd6, 1'b0, 1'b0, 0);
    check("t2_lb_13", last_wd, 32'h0000007F);
    op(0, LBU, 32'h13, 32'h0, 5'd7, 1'b0, 1'b0, 0);
    op(0, SB,  32'h11, 32'h00000080, 5'd0, 1'b0, 1'b0, 0);
    op(0, LB,  32'h11, 32'h0, 5'd8, 1'b0, 1'b0, 0);
    check("t2_lb_11", last_wd, 32'hFFFFFF80);
    op(0, LBU, 32'h11, 32'h0, 5'd8, 1'b0, 1'b0, 0);
    check("t2_lbu_11", last_wd, 32'h00000080);
    op(0, LW,  32'h10, 32'h0, 5'd8, 1'b0, 1'b0, 0);
    check("t2_lw_10", last_wd, 32'h7FAD80EF);

    // Wait states with in_valid held high throughout.
    op(1, LW, 32'h10, 32'h0, 5'd11, 1'b0, 1'b1, 0);

    // Misaligned accesses leave RAM alone.
    op(0, LW, 32'h02, 32'h0, 5'd3, 1'b0, 1'b0, 0);
    op(0, SH, 32'h05, 32'h0000FFFF, 5'd0, 1'b0, 1'b0, 0);
    op(0, LW, 32'h04, 32'h0, 5'd3, 1'b0, 1'b0, 0);
    op(1, SW, 32'h06, 32'h12345678, 5'd0, 1'b0, 1'b0, 0);
    op(1, LW, 32'h04, 32'h0, 5'd3, 1'b0, 1'b0, 0);

    // Non-memory pass-through.
    op(0, 6'h00, 32'h1234, 32'h0, 5'd9, 1'b1, 1'b0, 0);
    check("t5_nonmem_data", last_wd, 32'h00001234);
    op(0, 6'h08, 32'hCAFE0001, 32'h0, 5'd10, 1'b0, 1'b0, 0);

    // Reset mid-store discards the write.
    op(1, SW, 32'h20, 32'h0, 5'd0, 1'b0, 1'b0, 0);
    op(1, SW, 32'h20, 32'hAAAA5555, 5'd0, 1'b0, 1'b0, 1);
    op(1, LW, 32'h20, 32'h0, 5'd12, 1'b0, 1'b0, 0);
    check("t6_rst_store_dropped", last_wd, 32'h0);

    // Address wrap modulo DEPTH*4.
    op(0, SW, 32'h1000, 32'h13579BDF, 5'd0, 1'b0, 1'b0, 0);
    op(0, LW, 32'h0, 32'h0, 5'd13, 1'b0, 1'b0, 0);
    check("t6_wrap", last_wd, 32'h13579BDF);

    // Random mix on both instances.
    for (int i = 0; i < 120; i++) begin
      rd = i % 2;
      if ($urandom_range(0, 9) < 8) begin
        ropc = mem_ops[$urandom_range(0, 7)];
        ra   = ($urandom() & 32'hFFFFF000) | (32'($urandom_range(0, 15)) << 2) |
               32'($urandom_range(0, 3));
      end else begin
        ropc = 6'($urandom_range(0, 31));
        ra   = $urandom();
      end
      op(rd, ropc, ra, $urandom(), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'b0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
